// File: rtl/hamming_enc_pkg.sv
// hamming_enc_pkg: Hamming(15,11) layout constants shared by the encoder and the team decoder.
package hamming_enc_pkg;
    localparam int DATA_W = 11;
    localparam int CODE_W = 15;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [CODE_W-1:0] code_t;

    // out_code index = 15 - Hamming position
    localparam int P1_IDX = 14;
    localparam int P2_IDX = 13;
    localparam int P4_IDX = 11;
    localparam int P8_IDX = 7;

    // DATA_IDX[i] is the out_code index carrying in_data[i]
    localparam int DATA_IDX [DATA_W] = '{0, 1, 2, 3, 4, 5, 6, 8, 9, 10, 12};

    // Data indices covered by each parity bit (even parity)
    localparam code_t P1_MASK = 15'h1555;
    localparam code_t P2_MASK = 15'h1333;
    localparam code_t P4_MASK = 15'h070F;
    localparam code_t P8_MASK = 15'h007F;
endpackage

// File: rtl/hamming_enc_core.sv
// hamming_enc_core: combinational Hamming(15,11) encode followed by optional single-bit error injection.
module hamming_enc_core
    import hamming_enc_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    input  logic              inj_en,
    input  logic [3:0]        inj_pos,
    output logic [CODE_W-1:0] code
);
    code_t raw;
    code_t inj_mask;

    always_comb begin
        raw = '0;
        for (int i = 0; i < DATA_W; i++) raw[DATA_IDX[i]] = data[i];
        // masks never cover parity indices, so the order of these four is irrelevant
        raw[P1_IDX] = ^(raw & P1_MASK);
        raw[P2_IDX] = ^(raw & P2_MASK);
        raw[P4_IDX] = ^(raw & P4_MASK);
        raw[P8_IDX] = ^(raw & P8_MASK);
    end

    assign inj_mask = (inj_en && inj_pos != 4'd0) ? code_t'(1) << (4'd15 - inj_pos) : '0;
    assign code     = raw ^ inj_mask;
endmodule

// File: rtl/hamming_enc.sv
// hamming_enc: Hamming(15,11) encoder with a DEPTH-entry output FIFO and accepted-word counter.
module hamming_enc
    import hamming_enc_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              inj_en,
    input  logic [3:0]        inj_pos,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] out_code,
    output logic [15:0]       word_cnt
);
    localparam int AW = $clog2(DEPTH);

    code_t         mem [DEPTH];
    code_t         enc;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   occ;
    logic          push;
    logic          pop;

    hamming_enc_core u_core (
        .data    (in_data),
        .inj_en  (inj_en),
        .inj_pos (inj_pos),
        .code    (enc)
    );

    assign in_ready  = occ < (AW+1)'(DEPTH);
    assign out_valid = occ != '0;
    assign out_code  = mem[rd_ptr];
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            word_cnt <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            wr_ptr   <= wr_ptr + AW'(push);
            rd_ptr   <= rd_ptr + AW'(pop);
            occ      <= occ + (AW+1)'(push) - (AW+1)'(pop);
            word_cnt <= word_cnt + 16'(push);
        end
    end

    // storage is deliberately unreset; out_valid gates its meaning
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= enc;
    end
endmodule
